// File: rtl/print_pkg.sv
// print_pkg: shared encodings, states, ASCII constants and nibble formatter
package print_pkg;
  localparam logic [1:0] MODE_RAW      = 2'd0;
  localparam logic [1:0] MODE_HEX      = 2'd1;
  localparam logic [1:0] MODE_HEX_CRLF = 2'd2;
  localparam logic [1:0] MODE_RAW_CRLF = 2'd3;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_US = 8'h5F;
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/posedge_sel.sv
// posedge_sel: rising-edge detector that ignores a level already high at reset release
module posedge_sel (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic p
);
  logic q, armed;
  // history of d, plus an arm bit set only once d has been seen low
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      q     <= 1'b0;
      armed <= 1'b0;
    end else begin
      q     <= d;
      armed <= armed | ~d;
    end
  assign p = d & ~q & armed;
endmodule

// File: rtl/print_fmt.sv
// print_fmt: prints a latched payload as raw byte or grouped hex, optional CRLF
module print_fmt import print_pkg::*; #(
  parameter int          DATA_W    = 32,
  parameter int          SEP_EVERY = 4,
  parameter logic [7:0]  SEP_CHAR  = ASCII_US
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] dout_tx,
  input  logic [1:0]        mode_tx,
  input  logic              req_tx,
  input  logic              rdy_tx,
  output logic              vld_tx,
  output logic [7:0]        d_tx,
  output logic              ack_tx,
  output logic              busy
);
  localparam int ND   = DATA_W / 4;
  localparam int NS   = SEP_EVERY > 0 ? (ND - 1) / SEP_EVERY : 0;
  localparam int MAXC = ND + NS + 2;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int GW   = SEP_EVERY > 1 ? $clog2(SEP_EVERY) : 1;
  state_t st, st_n;
  logic [DATA_W-1:0] data_q;
  logic [1:0] mode_q;
  logic [CW-1:0] cc, pay_len, tot;
  logic [GW-1:0] gc;
  logic sep, start, hex, crlf, xfer, last;
  logic [7:0] ch;
  posedge_sel u_edge (.clk(clk), .rstn(rstn), .d(req_tx), .p(start));
  assign hex     = mode_q == MODE_HEX || mode_q == MODE_HEX_CRLF;
  assign crlf    = mode_q[1];
  assign pay_len = hex ? CW'(ND + NS) : CW'(1);
  assign tot     = pay_len + (crlf ? CW'(2) : CW'(0));
  assign last    = cc == tot - CW'(1);
  assign vld_tx  = st == SEND;
  assign ack_tx  = st == DONE;
  assign busy    = st != IDLE;
  assign xfer    = vld_tx & rdy_tx;
  assign d_tx    = vld_tx ? ch : 8'h00;
  // character for the current position: CRLF tail, raw byte, separator or hex digit
  always_comb
    ch = cc >= pay_len ? (cc == pay_len ? ASCII_CR : ASCII_LF) :
         !hex ? data_q[7:0] :
         sep ? SEP_CHAR : nib2ascii(data_q[DATA_W-1 -: 4]);
  // job state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) st <= IDLE;
    else st <= st_n;
  // next state: only IDLE honours a start, SEND leaves on the last transfer
  always_comb begin
    st_n = st;
    st_n = st == IDLE ? (start ? LOAD : IDLE) :
           st == LOAD ? SEND :
           st == SEND ? (xfer && last ? DONE : SEND) : IDLE;
  end
  // payload latch, character counter and separator sequencing
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      data_q <= '0;
      mode_q <= '0;
      cc     <= '0;
      gc     <= '0;
      sep    <= 1'b0;
    end else if (st == IDLE && start) begin
      data_q <= dout_tx;
      mode_q <= mode_tx;
      cc     <= '0;
      gc     <= '0;
      sep    <= 1'b0;
    end else if (xfer) begin
      cc <= cc + CW'(1);
      if (hex && cc < pay_len) begin
        if (sep) sep <= 1'b0;
        else begin
          data_q <= data_q << 4;
          if (SEP_EVERY > 0 && gc == GW'(SEP_EVERY - 1) && cc != pay_len - CW'(1)) begin
            sep <= 1'b1;
            gc  <= '0;
          end else if (SEP_EVERY > 0) gc <= gc + GW'(1);
        end
      end
    end
endmodule
